// File: rtl/cordic_atan2_q16_pkg.sv
// cordic_atan2_q16_pkg: shared Q16.16 degree constants, atan_deg table and FSM encoding
package cordic_atan2_q16_pkg;
  localparam logic signed [31:0] DEG_90 = 32'sh005A0000;
  localparam logic signed [31:0] DEG_180 = 32'sh00B40000;
  localparam logic [31:0] CORDIC_K = 32'h00009B75;
  localparam logic [31:0] CORDIC_AN = 32'h0001A592;
  localparam logic [23:0][31:0] ATAN_DEG = {
    32'h00000000, 32'h00000001, 32'h00000002, 32'h00000004,
    32'h00000007, 32'h0000000E, 32'h0000001D, 32'h00000039,
    32'h00000073, 32'h000000E5, 32'h000001CA, 32'h00000395,
    32'h00000729, 32'h00000E53, 32'h00001CA6, 32'h0000394C,
    32'h00007297, 32'h0000E52A, 32'h0001CA38, 32'h0003938B,
    32'h00072001, 32'h000E0947, 32'h001A90A7, 32'h002D0000
  };
  typedef enum logic [1:0] {S_IDLE, S_PREROT, S_ITER, S_OUT} state_t;
endpackage

// File: rtl/cordic_atan2_q16_if.sv
// cordic_atan2_q16_if: start/done request bundle with operands and results
interface cordic_atan2_q16_if;
  logic start;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [31:0] angle_deg;
  logic [31:0] magnitude;
  logic busy;
  logic done;
  modport master(output start, x_in, y_in, input angle_deg, magnitude, busy, done);
  modport slave(input start, x_in, y_in, output angle_deg, magnitude, busy, done);
endinterface

// File: rtl/cordic_atan_deg_rom.sv
// cordic_atan_deg_rom: index -> atan(2^-i) in Q16.16 degrees, combinational
module cordic_atan_deg_rom
  import cordic_atan2_q16_pkg::*;
(
  input logic [4:0] idx,
  output logic [31:0] deg
);
  assign deg = idx < 5'd24 ? ATAN_DEG[idx] : '0;
endmodule

// File: rtl/cordic_atan2_q16.sv
// cordic_atan2_q16: iterative vectoring CORDIC, atan2 in Q16.16 degrees plus magnitude
// CORDIC_MAG_COMP_EN scales the magnitude by 1/An so it reports true vector length
module cordic_atan2_q16
  import cordic_atan2_q16_pkg::*;
#(
  parameter int ITERATIONS = 16,
  parameter int GUARD = 2
) (
  input logic clk,
  input logic rst,
  cordic_atan2_q16_if.slave bus
);
  localparam int W = 32 + GUARD;
  state_t state, state_n;
  logic [4:0] cnt;
  logic signed [W-1:0] x, y, dx, dy;
  logic signed [31:0] z, z_out;
  logic [31:0] atan_i, mag_n, angle_q, mag_q;
  logic zero, done_q, accept, last, neg_x, neg_y;
  cordic_atan_deg_rom rom (.idx(cnt), .deg(atan_i));
  assign accept = state == S_IDLE && bus.start && !done_q;
  assign last = cnt == 5'(ITERATIONS - 1);
  assign dx = x >>> cnt;
  assign dy = y >>> cnt;
  assign neg_x = x[W-1];
  assign neg_y = y[W-1];
  // a null vector never rotates toward y=0, so z would drift to sum(atan); force 0
  assign z_out = zero ? '0 : (z <= -DEG_180 || z > DEG_180) ? DEG_180 : z;
`ifdef CORDIC_MAG_COMP_EN
  assign mag_n = 32'(({{17{x[W-1]}}, x} * (W + 17)'(CORDIC_K)) >> 16);
`else
  assign mag_n = x[31:0];
`endif
  always_comb begin
    state_n = state == S_IDLE ? (accept ? S_PREROT : S_IDLE) :
              state == S_PREROT ? S_ITER :
              state == S_ITER ? (last ? S_OUT : S_ITER) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      z <= '0;
      cnt <= '0;
      zero <= 1'b0;
      angle_q <= '0;
      mag_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == S_OUT;
      if (accept) begin
        x <= W'($signed(bus.x_in));
        y <= W'($signed(bus.y_in));
      end
      if (state == S_PREROT) begin
        x <= neg_x ? (neg_y ? -y : y) : x;
        y <= neg_x ? (neg_y ? x : -x) : y;
        z <= neg_x ? (neg_y ? -DEG_90 : DEG_90) : '0;
        zero <= x == '0 && y == '0;
        cnt <= '0;
      end
      if (state == S_ITER) begin
        x <= neg_y ? x - dy : x + dy;
        y <= neg_y ? y + dx : y - dx;
        z <= neg_y ? z - $signed(atan_i) : z + $signed(atan_i);
        cnt <= cnt + 5'd1;
      end
      if (state == S_OUT) begin
        angle_q <= z_out;
        mag_q <= mag_n;
      end
    end
  end
  assign bus.busy = state != S_IDLE;
  assign bus.done = done_q;
  assign bus.angle_deg = angle_q;
  assign bus.magnitude = mag_q;
endmodule

// File: tb/tb_cordic_atan2_q16.sv
// tb_cordic_atan2_q16: scoreboard bench, real-valued atan2/hypot reference
module tb_cordic_atan2_q16;
  localparam int ITER = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cordic_atan2_q16_if bus ();
  cordic_atan2_q16 #(.ITERATIONS(ITER), .GUARD(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int x;
    int y;
    real ang;
    real mag;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int passed = 0, total = 0, cyc = 0, acc_cyc = 0;
  real gain, a, d, dm;
  bit prev_done = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string name, input string info);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, info);
  endtask
  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.x = x;
    e.y = y;
    e.ang = (x == 0 && y == 0) ? 0.0 : $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
    e.mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * gain;
    e.cyc = 0;
    return e;
  endfunction
  task automatic issue(input int x, input int y);
    exp_t e;
    int n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk(1'b0, "idle_timeout", $sformatf("busy=%b done=%b want idle", bus.busy, bus.done));
    bus.start = 1'b1;
    bus.x_in = x;
    bus.y_in = y;
    e = model(x, y);
    acc_cyc = cyc + 1;
    e.cyc = acc_cyc + ITER + 2;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done && prev_done) chk(1'b0, "done_pulse_width", "done high two cycles, want one");
      if (bus.done) begin
        if (sb.size() == 0) chk(1'b0, "unexpected_done", $sformatf("angle=%h mag=%h with nothing pending", bus.angle_deg, bus.magnitude));
        else begin
          me = sb.pop_front();
          a = real'($signed(bus.angle_deg)) / 65536.0;
          d = a - me.ang;
          if (d > 180.0) d = d - 360.0;
          if (d < -180.0) d = d + 360.0;
          dm = real'(bus.magnitude) - me.mag;
          chk(cyc == me.cyc, "latency", $sformatf("done at edge %0d want %0d", cyc, me.cyc));
          chk((d < 0 ? -d : d) * 65536.0 <= 655.0, "angle", $sformatf("x=%h y=%h got %h (%f) want %f deg", me.x, me.y, bus.angle_deg, a, me.ang));
          chk((dm < 0 ? -dm : dm) <= 66.0, "magnitude", $sformatf("x=%h y=%h got %0d want %f", me.x, me.y, bus.magnitude, me.mag));
          chk(!bus.busy, "busy_in_done", "busy=1 want 0");
          if (me.y == 0 && me.x < 0) chk($signed(bus.angle_deg) > 0, "angle_positive", $sformatf("got %h want +180", bus.angle_deg));
        end
      end
    end
    prev_done = bus.done;
  end
  initial begin
    int n, x, y;
    real an = 1.0;
    bus.start = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    for (int i = 0; i < ITER; i++) an = an * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef CORDIC_MAG_COMP_EN
    gain = an * 39797.0 / 65536.0;
`else
    gain = an;
`endif
    repeat (3) @(negedge clk);
    chk(bus.angle_deg == 0 && bus.magnitude == 0 && !bus.busy && !bus.done, "reset_state",
        $sformatf("angle=%h mag=%h busy=%b done=%b want all 0", bus.angle_deg, bus.magnitude, bus.busy, bus.done));
    rst = 1'b0;
    @(negedge clk);
    issue(65536, 65536);
    issue(-65536, 0);
    issue(0, -65536);
    issue(0, 0);
    issue(65536, 0);
    issue(0, 65536);
    issue(-65536, 65536);
    issue(-65536, -65536);
    issue(1 << 30, -(1 << 30));
    issue(1 << 30, 1 << 30);
    issue(-(1 << 30), 0);
    issue(-(1 << 30), -1000);
    issue(-(1 << 30), 1000);
    issue(3 * 65536, -4 * 65536);
    repeat (5) @(negedge clk);
    chk(bus.busy, "busy_mid_iter", "busy=0 want 1");
    bus.start = 1'b1;
    bus.x_in = -7 * 65536;
    bus.y_in = 2 * 65536;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(bus.done, "done_wait", "no done within 40 cycles");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk(!bus.busy, "start_in_done_ignored", "busy=1 want 0");
    issue(3 * 65536, 5 * 65536);
    while (cyc < acc_cyc + 6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(bus.angle_deg == 0 && bus.magnitude == 0 && !bus.busy && !bus.done, "reset_abort",
        $sformatf("angle=%h mag=%h busy=%b done=%b want all 0", bus.angle_deg, bus.magnitude, bus.busy, bus.done));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(65536, 0);
    for (int k = 0; k < 24; k++) begin
      n = 0;
      do begin
        x = int'($urandom) >>> $urandom_range(1, 12);
        y = int'($urandom) >>> $urandom_range(1, 12);
        n++;
      end while ((x < (1 << 20) && x > -(1 << 20) && y < (1 << 20) && y > -(1 << 20)) && n < 100);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(x, y);
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk(1'b0, "drain_timeout", $sformatf("%0d results outstanding, want 0", sb.size()));
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
